// File: rtl/imem_pkg.sv
// Shared constants and encodings for the instruction-memory responder.
package imem_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    typedef enum logic [1:0] {
        BOOT  = ST_BOOT,
        LOAD  = ST_LOAD,
        RUN   = ST_RUN,
        FAULT = ST_FAULT
    } state_e;

    // Reserved: a later revision may report why the fetch faulted.
    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_RANGE    = 2'd2,
        FC_RSVD     = 2'd3
    } fault_cause_e;

endpackage

// File: rtl/imem_array.sv
// Program word storage: synchronous write, asynchronous read, contents survive reset.
module imem_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Memory end of the IFU fetch port: boot-time word-stream loader, same-cycle
// instruction read, and halt/fault generation for bad fetch addresses.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   imem_i_iaddr,
    output logic [31:0]   imem_o_idata,
    output logic          imem_o_halt,
    output logic          imem_o_fault,
    input  logic          imem_i_load_start,
    input  logic          imem_i_load_valid,
    input  logic [31:0]   imem_i_load_data,
    input  logic          imem_i_load_last,
    output logic          imem_o_load_ready,
    output logic          imem_o_load_done,
    output logic [AW:0]   imem_o_load_count
);

    localparam logic [32:0]   SPAN    = 33'(DEPTH_WORDS) << 2;
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH_WORDS - 1);

    state_e        state, state_nxt;
    logic [AW-1:0] ptr;
    logic [AW:0]   count;
    logic          fault, load_done;
    logic [31:0]   offset, rdata;
    logic          good, accept, load_end, start_load, go_fault;

    // The 33-bit compare keeps the range check exact even for spans near 4 GiB.
    assign offset = imem_i_iaddr - BASE_ADDR;
    assign good   = (imem_i_iaddr[1:0] == 2'b00) && (imem_i_iaddr >= BASE_ADDR)
                    && ({1'b0, offset} < SPAN);

    imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (accept),
        .waddr (ptr),
        .wdata (imem_i_load_data),
        .raddr (offset[AW+1:2]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            ptr       <= '0;
            count     <= '0;
            fault     <= 1'b0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            load_done <= load_end;
            if (start_load) begin
                ptr   <= '0;
                count <= '0;
                fault <= 1'b0;
            end else if (accept) begin
                ptr   <= ptr + 1'b1;
                count <= count + 1'b1;
            end
            if (go_fault) fault <= 1'b1;
        end
    end

    always_comb begin
        state_nxt         = state;
        imem_o_halt       = 1'b1;
        imem_o_idata      = NOP;
        imem_o_load_ready = 1'b0;
        accept            = 1'b0;
        load_end          = 1'b0;
        start_load        = 1'b0;
        go_fault          = 1'b0;
        case (state)
            BOOT: begin
                if (imem_i_load_start) begin
                    start_load = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                imem_o_load_ready = 1'b1;
                accept            = imem_i_load_valid;
                // A full array ends the load even without a last marker.
                if (accept && (imem_i_load_last || ptr == PTR_MAX)) begin
                    load_end  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (good) begin
                    imem_o_idata = rdata;
                    imem_o_halt  = 1'b0;
                end
                if (imem_i_load_start) begin
                    start_load = 1'b1;
                    state_nxt  = LOAD;
                end else if (!good) begin
                    go_fault  = 1'b1;
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                if (imem_i_load_start) begin
                    start_load = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign imem_o_fault      = fault;
    assign imem_o_load_done  = load_done;
    assign imem_o_load_count = count;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch interface that the IFU drives (iaddr out, idata in, same cycle).
- Holds program words in an internal array with combinational read, so the fetch path stays single-cycle.
- Loaded at boot through a valid/ready word-stream port.
- Drives the IFU halt input while no program is loaded or after a fetch fault.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit instruction words; must be a power of two, at least 2.
AW, $clog2(DEPTH_WORDS), word-index width (derived; do not override).
BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH_WORDS*4-aligned.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
imem_i_iaddr  input  32  fetch byte address from IFU
imem_o_idata  output  32  instruction returned in the same cycle
imem_o_halt  output  1  to IFU halt; 1 = freeze PC
imem_o_fault  output  1  sticky fetch fault (misaligned or out of range)
imem_i_load_start  input  1  1-cycle request to (re)load program
imem_i_load_valid  input  1  load word valid
imem_i_load_data  input  32  load word
imem_i_load_last  input  1  marks final load word
imem_o_load_ready  output  1  responder accepts load word
imem_o_load_done  output  1  1-cycle pulse after load completes
imem_o_load_count  output  AW+1  words written by last/current load

Behaviour:
- Reset is asynchronous and active-high. Reset values: state=BOOT, halt=1, fault=0, load_ready=0, load_done=0, load_count=0, write pointer=0. The array is not reset and keeps its contents across reset.
- NOP = 32'h0000_0013. imem_o_idata = NOP in every state except RUN with a good address.
- FSM states: BOOT, LOAD, RUN, FAULT.
- BOOT:
  - halt=1, ready=0.
  - load_start -> LOAD, with ptr=0 and count=0.
  - load_valid is ignored.
- LOAD:
  - halt=1, ready=1.
  - On valid&ready: mem[ptr]<=data, ptr++, count++.
  - Transition to RUN on an accepted word when last=1 or ptr==DEPTH_WORDS-1 (array full, auto-terminate; later words are not accepted).
  - load_done pulses for 1 cycle, in the first RUN cycle.
  - load_start is ignored in LOAD.
- RUN:
  - offset = iaddr - BASE_ADDR (32-bit).
  - good = (iaddr[1:0]==0) && (iaddr >= BASE_ADDR) && (offset < DEPTH_WORDS*4).
  - good: idata = mem[offset[AW+1:2]] combinationally, halt=0.
  - bad: idata=NOP and halt=1 combinationally in that same cycle, so the IFU PC does not advance past the faulting address. Next edge -> FAULT, fault<=1.
  - load_start -> LOAD (ptr=0, count=0, halt=1 from the next cycle). load_start takes priority over a bad address in the same cycle; fault is not set.
- FAULT:
  - halt=1, fault=1, idata=NOP.
  - Exit only via load_start (-> LOAD, fault cleared on that edge) or reset.
- Write/read collision: none possible, since reads are valid only in RUN and writes occur only in LOAD.
- Reset mid-load: partially written words remain; state=BOOT, count=0.
- load_count holds its value after the load until the next load_start.

Decomposition:
- Package imem_pkg: NOP constant, FSM state encoding (2-bit localparams), fault-cause encoding reserved for future use.
- One sub-module, imem_array: DEPTH_WORDS x 32, synchronous write, asynchronous read, no reset.
- FSM, address check and load counter live in imem_responder.

Test Plan:
- Reset, then idle 5 cycles -> halt=1, idata=32'h13, ready=0, fault=0; load_valid pulses in BOOT are not written.
- load_start, then 4 words 0xA0..0xA3 with last on the 4th (with valid gaps) -> count=4, done pulses once, halt=0. iaddr 0x0/0x4/0x8/0xC returns 0xA0..0xA3 in the same cycle.
- RUN with iaddr=0x2 -> halt=1 and idata=0x13 in the same cycle, fault=1 on the next edge and stays 1. load_start -> LOAD with fault=0.
- DEPTH_WORDS=4, stream 6 words without last -> 4 accepted, ready drops, count=4. iaddr=0x10 -> fault.
- Assert rst asynchronously mid-load after 2 words -> outputs at reset values immediately. Reload with 1 word -> word 0 new, word 1 keeps the old value.
- load_start coincident with bad iaddr in RUN -> LOAD entered, fault stays 0.
